// File: rtl/uart_rx_frame.sv
// uart_rx_frame: UART receive framing stage.
// Detects the start bit on the synchronized line, samples each bit at
// mid-bit using the oversample tick, checks the stop bit and presents the
// received word on a valid/ready handshake. Framing errors and overruns are
// reported as one-cycle pulses.
// Optional feature: define UART_RX_PARITY_EN to add an even-parity bit
// between the data bits and the stop bit, plus the parity_err output.
module uart_rx_frame #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  input  logic                 ready,
  output logic                 busy,
  output logic                 frame_err,
  output logic                 overrun
`ifdef UART_RX_PARITY_EN
  ,
  output logic                 parity_err
`endif
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);

  localparam logic [TW-1:0] T_HALF = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] T_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

`ifdef UART_RX_PARITY_EN
  localparam state_t S_AFTER_DATA = S_PARITY;
`else
  localparam state_t S_AFTER_DATA = S_STOP;
`endif

  logic                 rx_p0;
  logic                 rx_p1;
  logic                 rx_s;

  state_t               state_q;
  state_t               state_d;
  logic [TW-1:0]        tcnt_q;
  logic [TW-1:0]        tcnt_d;
  logic [BW-1:0]        bcnt_q;
  logic [BW-1:0]        bcnt_d;
  logic [DATA_BITS-1:0] shift_q;
  logic [DATA_BITS-1:0] shift_d;
  logic                 stop_hit;
  logic                 load;
  logic                 take;

`ifdef UART_RX_PARITY_EN
  logic                 par_q;
  logic                 par_d;
  logic                 par_ok;
`endif

  assign rx_s = rx_p1;
  assign busy = (state_q != S_IDLE);
  assign take = valid & ready;

  // Two-flop synchronizer for the asynchronous serial line, idle high.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_p0 <= 1'b1;
      rx_p1 <= 1'b1;
    end else begin
      rx_p0 <= rx;
      rx_p1 <= rx_p0;
    end
  end

  // FSM state, tick/bit counters and the receive shift register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      tcnt_q  <= '0;
      bcnt_q  <= '0;
      shift_q <= '0;
`ifdef UART_RX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      tcnt_q  <= tcnt_d;
      bcnt_q  <= bcnt_d;
      shift_q <= shift_d;
`ifdef UART_RX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  // Next-state logic: counters advance only on tick; stop_hit marks the
  // tick on which the stop bit is sampled.
  always_comb begin
    state_d  = state_q;
    tcnt_d   = tcnt_q;
    bcnt_d   = bcnt_q;
    shift_d  = shift_q;
    stop_hit = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d    = par_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (!rx_s) begin
          tcnt_d  = '0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (tick) begin
          if (tcnt_q == T_HALF) begin
            if (rx_s) begin
              state_d = S_IDLE;
            end else begin
              tcnt_d  = '0;
              bcnt_d  = '0;
              state_d = S_DATA;
            end
          end else begin
            tcnt_d = tcnt_q + 1'b1;
          end
        end
      end
      S_DATA: begin
        if (tick) begin
          if (tcnt_q == T_LAST) begin
            shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
            tcnt_d  = '0;
            bcnt_d  = bcnt_q + 1'b1;
            if (bcnt_q == B_LAST) begin
              state_d = S_AFTER_DATA;
            end
          end else begin
            tcnt_d = tcnt_q + 1'b1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (tick) begin
          if (tcnt_q == T_LAST) begin
            par_d   = rx_s;
            tcnt_d  = '0;
            state_d = S_STOP;
          end else begin
            tcnt_d = tcnt_q + 1'b1;
          end
        end
      end
`endif
      S_STOP: begin
        if (tick) begin
          if (tcnt_q == T_LAST) begin
            stop_hit = 1'b1;
            tcnt_d   = '0;
            state_d  = S_IDLE;
          end else begin
            tcnt_d = tcnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

`ifdef UART_RX_PARITY_EN
  // Even parity: data bits XOR parity bit must be zero.
  assign par_ok = ~(^{shift_q, par_q});
  assign load   = stop_hit & rx_s & par_ok;
`else
  assign load   = stop_hit & rx_s;
`endif

  // Output register: word delivery, handshake and error pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data      <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
    end else begin
      frame_err <= stop_hit & ~rx_s;
      overrun   <= load & valid & ~ready;
`ifdef UART_RX_PARITY_EN
      parity_err <= stop_hit & rx_s & ~par_ok;
`endif
      if (load) begin
        data  <= shift_q;
        valid <= 1'b1;
      end else if (take) begin
        valid <= 1'b0;
      end
    end
  end

endmodule
